mem_port_arbiter: RTL

Round-robin arbiter that shares one single-ported synchronous memory (register bank or data memory built from flip-flop storage) between `NUM_REQ` requesters, e.g. instruction fetch and load/store. It accepts one transaction at a time, latches the winner's command, drives the memory port, waits out a fixed memory latency, then returns read data with a completion pulse. It sits between pipeline stages and the memory array.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/round_robin_picker.sv | 34 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Counter must hold MEM_LATENCY itself, hence latency+1 codes.
    function automatic int cnt_width(input int latency);
        return (latency >= 1) ? $clog2(latency + 1) : 1;
    endfunction

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; master is the environment
// (requesters plus memory array), slave is the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          mem_en;
    logic                          mem_we;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic [DATA_WIDTH-1:0]         mem_rdata;

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/round_robin_picker.sv
// Combinational round-robin selector: first asserted request after `last`,
// wrapping, so the most recently granted requester has lowest priority.
module round_robin_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last,
    output logic [NUM_REQ-1:0] pick,
    output logic [PTR_W-1:0]   pick_idx,
    output logic               valid
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the search so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        pick     = '0;
        pick_idx = '0;
        valid    = 1'b0;
        idx      = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last) + off) % NUM_REQ;
            if (!valid && req[idx]) begin
                valid     = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported synchronous memory between
// NUM_REQ requesters, one transaction at a time with fixed memory latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int CNT_W = cnt_width(MEM_LATENCY);
    localparam int PTR_W = ptr_width(NUM_REQ);

    localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t              state_q, state_d;
    logic [PTR_W-1:0]        last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;

    logic [NUM_REQ-1:0]      pick;
    logic [PTR_W-1:0]        pick_idx;
    logic                    pick_valid;

    round_robin_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req      (bus.req),
        .last     (last_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments here so every flop samples the values
        // from before the edge, independent of statement order.
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= LAST_RST;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == CNT_ONE) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed one state early so that they come straight from flops.
    always_comb begin
        last_d      = last_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        gnt_d       = '0;
        done_d      = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    last_d      = pick_idx;
                    we_d        = bus.we[pick_idx];
                    mem_addr_d  = bus.addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata_d = bus.wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    gnt_d       = pick;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.we[pick_idx];
                end
            end
            ISSUE: cnt_d = CNT_LOAD;
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    done_d = NUM_REQ'(1) << last_q;
                    if (!we_q) rdata_d = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
